// File: rtl/fifo_vector_reader.sv
// fifo_vector_reader: drains an FWFT FIFO and packs VECTOR_LEN elements (lane 0 = first popped) into one vector.
// Latency: out_valid rises on the edge capturing the last element; each handoff costs one non-popping cycle.
// Backpressure: no pops while a vector is held (out_valid & ~out_ready); FIFO_READER_FLUSH_EN adds a flush port.
module fifo_vector_reader #(
    parameter int DATA_WIDTH  = 32,
    parameter int VECTOR_LEN  = 4,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             fifo_empty,
    input  logic [DATA_WIDTH-1:0]            fifo_r_data,
    output logic                             fifo_rd,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [DATA_WIDTH*VECTOR_LEN-1:0] out_data,
    output logic [COUNT_WIDTH-1:0]           vec_count
`ifdef FIFO_READER_FLUSH_EN
    ,
    input  logic                             flush
`endif
);

    localparam int IDX_W = (VECTOR_LEN > 1) ? $clog2(VECTOR_LEN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VECTOR_LEN - 1);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic             flush_req;
    logic             pop;
    logic             handoff;

`ifdef FIFO_READER_FLUSH_EN
    assign flush_req = flush;
`else
    assign flush_req = 1'b0;
`endif

    // Flush outranks both a pop and a handoff in the same cycle.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        fifo_rd   = 1'b0;
        pop       = 1'b0;
        handoff   = 1'b0;
        if (flush_req) begin
            state_nxt = FILL;
            idx_nxt   = '0;
        end else if (state == FILL) begin
            fifo_rd = ~fifo_empty;
            pop     = ~fifo_empty;
            if (!fifo_empty) begin
                if (idx == LAST_IDX) begin
                    idx_nxt   = '0;
                    state_nxt = HOLD;
                end else begin
                    idx_nxt = idx + IDX_W'(1);
                end
            end
        end else begin
            if (out_ready) begin
                handoff   = 1'b1;
                state_nxt = FILL;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= FILL;
            idx       <= '0;
            out_data  <= '0;
            vec_count <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            for (int k = 0; k < VECTOR_LEN; k++) begin
                if (pop && (idx == IDX_W'(k))) begin
                    out_data[k*DATA_WIDTH +: DATA_WIDTH] <= fifo_r_data;
                end
            end
            if (handoff) begin
                vec_count <= vec_count + COUNT_WIDTH'(1);
            end
        end
    end

    assign out_valid = (state == HOLD);

endmodule
